// File: rtl/blast_wall_clearer.sv
// Blast propagation engine: walks a detonation outward UP/DOWN/LEFT/RIGHT, streams flame tiles
// and issues wall-clear writes. Define BLAST_PIERCE_EN to let blasts continue through cleared walls.
module blast_wall_clearer #(
  parameter int MAZE_COLS = 19,
  parameter int MAZE_ROWS = 13,
  parameter int RANGE_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         bomb_col,
  input  logic [3:0]         bomb_row,
  input  logic [RANGE_W-1:0] blast_range,
  output logic               query_valid,
  output logic [4:0]         query_col,
  output logic [3:0]         query_row,
  input  logic [1:0]         tile_type,
  output logic               clr_valid,
  output logic [4:0]         clr_col,
  output logic [3:0]         clr_row,
  input  logic               clr_ready,
  output logic               flame_valid,
  output logic [4:0]         flame_col,
  output logic [3:0]         flame_row,
  output logic               busy,
  output logic               done,
  output logic [4:0]         walls_cleared
);

  typedef enum logic [2:0] {
    S_IDLE, S_CENTER, S_Q, S_W, S_CLR, S_NEXTDIR, S_DONE
  } state_t;

  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  localparam logic signed [5:0] COLS_S = 6'(MAZE_COLS);
  localparam logic signed [5:0] ROWS_S = 6'(MAZE_ROWS);

  state_t             state, stateNext;
  dir_t               dir, dirNext;
  logic [4:0]         bombCol;
  logic [3:0]         bombRow;
  logic [RANGE_W-1:0] blastRange;
  logic [RANGE_W:0]   step, stepNext;
  logic [4:0]         wallCount, wallCountNext;
  logic               loadBomb;

  logic signed [5:0]  stepS, tgtCol, tgtRow;
  logic               inBounds, stepPast;
  logic [4:0]         tgtColOut;
  logic [3:0]         tgtRowOut;

  assign stepS = signed'(6'(step));

  // Target tile in 6-bit signed space so row 0 UP / col 0 LEFT go negative instead of wrapping.
  always_comb begin
    tgtCol = signed'({1'b0, bombCol});
    tgtRow = signed'({2'b00, bombRow});
    case (dir)
      D_UP:    tgtRow = tgtRow - stepS;
      D_DOWN:  tgtRow = tgtRow + stepS;
      D_LEFT:  tgtCol = tgtCol - stepS;
      default: tgtCol = tgtCol + stepS;
    endcase
  end

  assign inBounds  = (tgtCol >= 6'sd0) && (tgtCol < COLS_S) &&
                     (tgtRow >= 6'sd0) && (tgtRow < ROWS_S);
  assign stepPast  = step > {1'b0, blastRange};
  assign tgtColOut = tgtCol[4:0];
  assign tgtRowOut = tgtRow[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      dir        <= D_UP;
      step       <= '0;
      wallCount  <= '0;
      bombCol    <= '0;
      bombRow    <= '0;
      blastRange <= '0;
    end else begin
      state     <= stateNext;
      dir       <= dirNext;
      step      <= stepNext;
      wallCount <= wallCountNext;
      if (loadBomb) begin
        bombCol    <= bomb_col;
        bombRow    <= bomb_row;
        blastRange <= blast_range;
      end
    end
  end

  always_comb begin
    stateNext     = state;
    dirNext       = dir;
    stepNext      = step;
    wallCountNext = wallCount;
    loadBomb      = 1'b0;
    query_valid   = 1'b0;
    query_col     = '0;
    query_row     = '0;
    clr_valid     = 1'b0;
    clr_col       = '0;
    clr_row       = '0;
    flame_valid   = 1'b0;
    flame_col     = '0;
    flame_row     = '0;
    busy          = 1'b1;
    done          = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          loadBomb      = 1'b1;
          wallCountNext = '0;
          stateNext     = S_CENTER;
        end
      end
      S_CENTER: begin
        flame_valid = 1'b1;
        flame_col   = bombCol;
        flame_row   = bombRow;
        dirNext     = D_UP;
        stepNext    = 1;
        stateNext   = S_Q;
      end
      S_Q: begin
        if (stepPast || !inBounds) begin
          stateNext = S_NEXTDIR;
        end else begin
          query_valid = 1'b1;
          query_col   = tgtColOut;
          query_row   = tgtRowOut;
          stateNext   = S_W;
        end
      end
      S_W: begin
        case (tile_type)
          2'd0: begin
            flame_valid = 1'b1;
            flame_col   = tgtColOut;
            flame_row   = tgtRowOut;
            stepNext    = step + 1'b1;
            stateNext   = S_Q;
          end
          2'd1: begin
            flame_valid = 1'b1;
            flame_col   = tgtColOut;
            flame_row   = tgtRowOut;
            stateNext   = S_CLR;
          end
          default: stateNext = S_NEXTDIR;
        endcase
      end
      S_CLR: begin
        // step is frozen here, so the target (and thus clr_col/clr_row) holds until the handshake.
        clr_valid = 1'b1;
        clr_col   = tgtColOut;
        clr_row   = tgtRowOut;
        if (clr_ready) begin
          if (wallCount != 5'd31) wallCountNext = wallCount + 1'b1;
`ifdef BLAST_PIERCE_EN
          stepNext  = step + 1'b1;
          stateNext = S_Q;
`else
          stateNext = S_NEXTDIR;
`endif
        end
      end
      S_NEXTDIR: begin
        stepNext  = 1;
        stateNext = S_Q;
        case (dir)
          D_UP:    dirNext = D_DOWN;
          D_DOWN:  dirNext = D_LEFT;
          D_LEFT:  dirNext = D_RIGHT;
          default: stateNext = S_DONE;
        endcase
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  assign walls_cleared = wallCount;

endmodule

// File: tb/tb_blast_wall_clearer.sv
// Self-checking bench for blast_wall_clearer: the bench plays the maze map and compares
// flame/query/clear streams against a tile-walking reference model.
module tb_blast_wall_clearer;

  logic       clk = 1'b0;
  logic       reset, start, clr_ready;
  logic [4:0] bomb_col;
  logic [3:0] bomb_row;
  logic [2:0] blast_range;
  logic [1:0] tile_type;
  logic       query_valid, clr_valid, flame_valid, busy, done;
  logic [4:0] query_col, clr_col, flame_col, walls_cleared;
  logic [3:0] query_row, clr_row, flame_row;

  blast_wall_clearer #(.MAZE_COLS(19), .MAZE_ROWS(13), .RANGE_W(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .bomb_col(bomb_col), .bomb_row(bomb_row), .blast_range(blast_range),
    .query_valid(query_valid), .query_col(query_col), .query_row(query_row),
    .tile_type(tile_type),
    .clr_valid(clr_valid), .clr_col(clr_col), .clr_row(clr_row), .clr_ready(clr_ready),
    .flame_valid(flame_valid), .flame_col(flame_col), .flame_row(flame_row),
    .busy(busy), .done(done), .walls_cleared(walls_cleared)
  );

  always #5 clk = ~clk;

`ifdef BLAST_PIERCE_EN
  localparam bit PIERCE = 1'b1;
`else
  localparam bit PIERCE = 1'b0;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [1:0] tileMap [0:18][0:12];
  logic [8:0] expF[$], expQ[$], expC[$], gotF[$], gotQ[$], gotC[$];
  int         expWalls;

  function automatic logic [8:0] pk(input int c, input int r);
    return {c[4:0], r[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fillMap(input int mode);
    for (int c = 0; c < 19; c++)
      for (int r = 0; r < 13; r++) begin
        int v;
        v = $urandom_range(0, 9);
        if (mode == 0) tileMap[c][r] = 2'd0;
        else tileMap[c][r] = (v < 6) ? 2'd0 : (v < 8) ? 2'd1 : (v < 9) ? 2'd2 : 2'd3;
      end
  endtask

  // Reference: walk each direction tile by tile until range, edge, column, or (non-pierce) wall.
  task automatic modelBlast(input int bc, input int br, input int rng);
    int dc[4] = '{0, 0, -1, 1};
    int dr[4] = '{-1, 1, 0, 0};
    expF.delete(); expQ.delete(); expC.delete();
    expWalls = 0;
    expF.push_back(pk(bc, br));
    for (int d = 0; d < 4; d++)
      for (int s = 1; s <= rng; s++) begin
        int c, r;
        c = bc + dc[d] * s;
        r = br + dr[d] * s;
        if (c < 0 || c >= 19 || r < 0 || r >= 13) break;
        expQ.push_back(pk(c, r));
        if (tileMap[c][r] >= 2) break;
        expF.push_back(pk(c, r));
        if (tileMap[c][r] == 1) begin
          expC.push_back(pk(c, r));
          if (expWalls < 31) expWalls++;
          if (!PIERCE) break;
        end
      end
  endtask

  task automatic compareQueues(input string tag);
    check({tag, "_nflame"}, gotF.size(), expF.size());
    for (int i = 0; i < expF.size() && i < gotF.size(); i++) check({tag, "_flame"}, gotF[i], expF[i]);
    check({tag, "_nquery"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) check({tag, "_query"}, gotQ[i], expQ[i]);
    check({tag, "_nclear"}, gotC.size(), expC.size());
    for (int i = 0; i < expC.size() && i < gotC.size(); i++) check({tag, "_clear"}, gotC[i], expC[i]);
  endtask

  task automatic runBlast(input string tag, input int bc, input int br, input int rng,
                          input int dly, input bit poke);
    int cyc, waitCnt, unstable, clrCycles, idleViol;
    bit prevHold;
    logic [8:0] lastClr;
    modelBlast(bc, br, rng);
    gotF.delete(); gotQ.delete(); gotC.delete();
    cyc = 0; waitCnt = dly; unstable = 0; clrCycles = 0; idleViol = 0; prevHold = 0; lastClr = '0;
    @(negedge clk);
    start = 1'b1; bomb_col = 5'(bc); bomb_row = 4'(br); blast_range = 3'(rng);
    @(negedge clk);
    start = 1'b0; bomb_col = 5'($urandom); bomb_row = 4'($urandom); blast_range = 3'($urandom);
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_walls_start"}, walls_cleared, 0);
    forever begin
      if (flame_valid) gotF.push_back({flame_col, flame_row});
      if (query_valid) begin
        gotQ.push_back({query_col, query_row});
        tile_type = tileMap[query_col][query_row];
      end
      if (clr_valid) begin
        clrCycles++;
        if (prevHold && {clr_col, clr_row} !== lastClr) unstable++;
        lastClr = {clr_col, clr_row};
        if (waitCnt == 0) begin
          clr_ready = 1'b1;
          gotC.push_back({clr_col, clr_row});
        end else begin
          clr_ready = 1'b0;
          waitCnt--;
        end
      end else begin
        clr_ready = 1'($urandom_range(0, 1));
        waitCnt = dly;
      end
      prevHold = clr_valid && !clr_ready;
      if (!busy && (flame_valid || query_valid || clr_valid)) idleViol++;
      if (done || cyc > 2000) break;
      start = poke && (cyc == 3);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_no_timeout"}, cyc <= 2000, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_walls"}, walls_cleared, expWalls);
    check({tag, "_clr_stable"}, unstable, 0);
    check({tag, "_clr_hold"}, clrCycles, expC.size() * (dly + 1));
    check({tag, "_idle_quiet"}, idleViol, 0);
    compareQueues(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_outs"}, {busy, query_valid, clr_valid, flame_valid}, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; clr_ready = 1'b0; tile_type = 2'd0;
    bomb_col = '0; bomb_row = '0; blast_range = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {query_valid, clr_valid, flame_valid, busy, done}, 0);
    check("reset_walls", walls_cleared, 0);
    reset = 1'b0;

    fillMap(0);
    runBlast("open_4_6", 4, 6, 2, 0, 0);
    runBlast("corner_0_0", 0, 0, 3, 0, 0);
    runBlast("corner_18_12", 18, 12, 7, 0, 1);
    runBlast("range0", 9, 6, 0, 0, 1);

    fillMap(0);
    tileMap[6][6] = 2'd1;
    runBlast("wall_6_6", 4, 6, 3, 5, 0);

    fillMap(0);
    tileMap[4][5] = 2'd2;
    runBlast("column_4_5", 4, 6, 3, 0, 0);

    // Reset while waiting in the clear handshake.
    fillMap(0);
    tileMap[6][6] = 2'd1;
    @(negedge clk);
    start = 1'b1; bomb_col = 5'd4; bomb_row = 4'd6; blast_range = 3'd3; clr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!clr_valid && n < 200) begin
      if (query_valid) tile_type = tileMap[query_col][query_row];
      n++;
      @(negedge clk);
    end
    check("rst_reach_clr", clr_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_clr_drop", {clr_valid, busy, flame_valid, query_valid}, 0);
    check("rst_walls", walls_cleared, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    runBlast("after_reset", 4, 6, 3, 0, 0);

    fillMap(0);
    tileMap[5][6] = 2'd1;
    tileMap[6][6] = 2'd1;
    runBlast("two_walls", 4, 6, 3, 1, 0);

    for (int t = 0; t < 40; t++) begin
      fillMap(1);
      runBlast($sformatf("rand%0d", t), $urandom_range(0, 18), $urandom_range(0, 12),
               $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
